// File: rtl/cpu_pkg.sv
// cpu_pkg -- definitions shared across the CPU pipeline.
//   mem_state_t         : MEM-stage data-memory access FSM states
//   MEM_TIMEOUT_DEFAULT : default WAIT-cycle limit before a memory access aborts
//   DATA_W / REG_ADR_W  : datapath word width and register-address width
package cpu_pkg;

  localparam int DATA_W    = 16;
  localparam int REG_ADR_W = 3;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if -- data-memory request/response bus.
//   dmem_req   : request valid, held until dmem_ack
//   dmem_we    : 1 = write, 0 = read
//   dmem_addr  : request address
//   dmem_wdata : write data
//   dmem_rdata : read data, valid in the dmem_ack cycle
//   dmem_ack   : one-cycle completion pulse
// master = CPU side (mem_access), slave = memory side.
interface mem_access_if;
  import cpu_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/flopr.sv
// flopr -- WIDTH-bit register with asynchronous active-low reset to zero.
//   clk   : clock
//   reset : asynchronous active-low reset
//   d / q : data in / registered data out
module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/mem_timer.sv
// mem_timer -- 8-bit WAIT-cycle counter for the data-memory access FSM.
//   clk    : clock
//   reset  : asynchronous active-low reset
//   clear  : zero the count (entry to WAIT)
//   enable : count one more cycle without ack
//   tc     : terminal count; this cycle's increment reaches TIMEOUT
module mem_timer
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  // tc looks one count ahead so the abort lands on the edge where the
  // count would reach TIMEOUT, i.e. after exactly TIMEOUT WAIT cycles.
  localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      count <= 8'd0;
    else if (clear)  count <= 8'd0;
    else if (enable) count <= count + 8'd1;
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/mem_access.sv
// mem_access -- MEM pipeline stage: issues data-memory loads/stores, stalls
// the upstream pipeline while a request is outstanding, and owns MEM/WB.
//   clk, reset                 : clock, asynchronous active-low reset
//   ALUres_mem                 : address for load/store, writeback data otherwise
//   rd1_mem                    : store data
//   regwrite_adr_mem           : destination register
//   main_mem_write             : store request (wins over load)
//   regwrite_dat_controll_mem  : load request
//   regwrite_mem               : register write enable
//   dmem                       : data-memory bus (master side)
//   stall_mem                  : freezes IF..EX/MEM while asserted
//   regwrite_wb/_adr_wb/_dat_wb: MEM/WB pipeline register
//   mem_err                    : sticky timeout flag, cleared only by reset
module mem_access
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    ALUres_mem,
  input  logic [DATA_W-1:0]    rd1_mem,
  input  logic [REG_ADR_W-1:0] regwrite_adr_mem,
  input  logic                 main_mem_write,
  input  logic                 regwrite_dat_controll_mem,
  input  logic                 regwrite_mem,
  mem_access_if.master         dmem,
  output logic                 stall_mem,
  output logic                 regwrite_wb,
  output logic [REG_ADR_W-1:0] regwrite_adr_wb,
  output logic [DATA_W-1:0]    regwrite_dat_wb,
  output logic                 mem_err
);

  mem_state_t        state_q, state_d;
  logic              req_q, req_d, we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [DATA_W-1:0] load_data, load_d;
  logic              err_q, err_d;
  logic              tmr_clear, tmr_en, tmr_tc;
  logic              mem_op, is_load;

  // A store that is also flagged as a load is treated as a store.
  assign mem_op  = main_mem_write | regwrite_dat_controll_mem;
  assign is_load = regwrite_dat_controll_mem & ~main_mem_write;

  // DONE releases the stall so the completed op can leave the stage.
  assign stall_mem = mem_op & (state_q != DONE);

  mem_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .tc     (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    load_d    = load_data;
    err_d     = err_q;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          state_d   = WAIT;
          req_d     = 1'b1;
          we_d      = main_mem_write;
          addr_d    = ALUres_mem;
          wdata_d   = rd1_mem;
          tmr_clear = 1'b1;
        end
      end
      WAIT: begin
        tmr_en = ~dmem.dmem_ack;
        // Ack wins over a simultaneous terminal count.
        if (dmem.dmem_ack) begin
          load_d  = dmem.dmem_rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (tmr_tc) begin
          load_d  = '0;
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      load_data <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      load_data <= load_d;
      err_q     <= err_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign mem_err         = err_q;

  // MEM/WB: a stall inserts a bubble (write enable low, adr/dat held).
  logic                 wb_we_d;
  logic [REG_ADR_W-1:0] wb_adr_d;
  logic [DATA_W-1:0]    wb_dat_d;

  assign wb_we_d  = stall_mem ? 1'b0 : regwrite_mem;
  assign wb_adr_d = stall_mem ? regwrite_adr_wb : regwrite_adr_mem;
  assign wb_dat_d = stall_mem ? regwrite_dat_wb :
                    (is_load ? load_data : ALUres_mem);

  flopr #(.WIDTH(1)) u_wb_we (
    .clk (clk), .reset (reset), .d (wb_we_d), .q (regwrite_wb)
  );

  flopr #(.WIDTH(REG_ADR_W)) u_wb_adr (
    .clk (clk), .reset (reset), .d (wb_adr_d), .q (regwrite_adr_wb)
  );

  flopr #(.WIDTH(DATA_W)) u_wb_dat (
    .clk (clk), .reset (reset), .d (wb_dat_d), .q (regwrite_dat_wb)
  );

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access -- self-checking bench for mem_access (TIMEOUT = 4).
// Each operation is described by what it is (ALU/load/store) and when the
// memory acks; the expected stall length, bus contents and MEM/WB result
// follow from those rules directly.
module tb_mem_access;

  localparam int TIMEOUT_T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ALUres_mem, rd1_mem;
  logic [2:0]  regwrite_adr_mem;
  logic        main_mem_write, regwrite_dat_controll_mem, regwrite_mem;
  logic        stall_mem, regwrite_wb, mem_err;
  logic [2:0]  regwrite_adr_wb;
  logic [15:0] regwrite_dat_wb;

  mem_access_if dmem_bus ();

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: last MEM/WB contents and the sticky error flag.
  bit          err_model;
  logic        exp_wb;
  logic [2:0]  exp_adr;
  logic [15:0] exp_dat;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(TIMEOUT_T)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .ALUres_mem                (ALUres_mem),
    .rd1_mem                   (rd1_mem),
    .regwrite_adr_mem          (regwrite_adr_mem),
    .main_mem_write            (main_mem_write),
    .regwrite_dat_controll_mem (regwrite_dat_controll_mem),
    .regwrite_mem              (regwrite_mem),
    .dmem                      (dmem_bus),
    .stall_mem                 (stall_mem),
    .regwrite_wb               (regwrite_wb),
    .regwrite_adr_wb           (regwrite_adr_wb),
    .regwrite_dat_wb           (regwrite_dat_wb),
    .mem_err                   (mem_err)
  );

  task automatic set_idle();
    ALUres_mem                = 16'h0000;
    rd1_mem                   = 16'h0000;
    regwrite_adr_mem          = 3'd0;
    main_mem_write            = 1'b0;
    regwrite_dat_controll_mem = 1'b0;
    regwrite_mem              = 1'b0;
  endtask

  // One EX/MEM operation held until it leaves the stage. k = WAIT cycle in
  // which the ack arrives (k > TIMEOUT_T means the memory never answers).
  // Called at posedge+1, returns at posedge+1.
  task automatic run_op(input bit st, input bit ld, input logic [15:0] alu,
                        input logic [15:0] wd, input logic [2:0] adr,
                        input bit rw, input int k, input logic [15:0] rd,
                        input bit ack_in_done);
    bit memop, isld, tmo;
    int last;
    memop = st | ld;
    isld  = ld & ~st;
    tmo   = memop && (k > TIMEOUT_T);
    last  = !memop ? -1 : (tmo ? TIMEOUT_T : k);
    main_mem_write            = st;
    regwrite_dat_controll_mem = ld;
    ALUres_mem                = alu;
    rd1_mem                   = wd;
    regwrite_adr_mem          = adr;
    regwrite_mem              = rw;
    for (int c = 0; c <= last + 1; c++) begin
      @(negedge clk);
      n_checks++;
      if (stall_mem !== (c <= last)) begin
        n_fail++;
        $display("FAIL stall c=%0d: got %b expected %b", c, stall_mem, (c <= last));
      end
      if (memop && c >= 1 && c <= last) begin
        n_checks++;
        if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_wdata}
            !== {1'b1, st, alu, wd}) begin
          n_fail++;
          $display("FAIL wait_bus c=%0d: got req=%b we=%b addr=%h wdata=%h expected req=1 we=%b addr=%h wdata=%h",
                   c, dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr,
                   dmem_bus.dmem_wdata, st, alu, wd);
        end
      end
      if (c == 0 || c == last + 1) begin
        n_checks++;
        if (dmem_bus.dmem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL req_idle c=%0d: got %b expected 0", c, dmem_bus.dmem_req);
        end
      end
      if (c >= 1) begin
        n_checks++;
        if ({regwrite_wb, regwrite_adr_wb, regwrite_dat_wb} !== {1'b0, exp_adr, exp_dat}) begin
          n_fail++;
          $display("FAIL bubble c=%0d: got we=%b adr=%0d dat=%h expected we=0 adr=%0d dat=%h",
                   c, regwrite_wb, regwrite_adr_wb, regwrite_dat_wb, exp_adr, exp_dat);
        end
      end
      if (memop && !tmo && c == k) begin
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = rd;
      end
      if (memop && ack_in_done && c == last + 1) begin
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = ~rd;
      end
      @(posedge clk);
      #1;
      dmem_bus.dmem_ack   = 1'b0;
      dmem_bus.dmem_rdata = 16'($urandom);
    end
    if (tmo) err_model = 1'b1;
    exp_wb  = rw;
    exp_adr = adr;
    exp_dat = isld ? (tmo ? 16'h0000 : rd) : alu;
    n_checks++;
    if ({regwrite_wb, regwrite_adr_wb, regwrite_dat_wb} !== {exp_wb, exp_adr, exp_dat}) begin
      n_fail++;
      $display("FAIL memwb: got we=%b adr=%0d dat=%h expected we=%b adr=%0d dat=%h",
               regwrite_wb, regwrite_adr_wb, regwrite_dat_wb, exp_wb, exp_adr, exp_dat);
    end
    n_checks++;
    if (mem_err !== err_model) begin
      n_fail++;
      $display("FAIL mem_err: got %b expected %b", mem_err, err_model);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_idle();
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_wdata} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h expected all 0",
               dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_wdata);
    end
    n_checks++;
    if ({stall_mem, regwrite_wb, regwrite_adr_wb, regwrite_dat_wb, mem_err} !== 22'h0) begin
      n_fail++;
      $display("FAIL reset_out: got stall=%b we=%b adr=%0d dat=%h err=%b expected all 0",
               stall_mem, regwrite_wb, regwrite_adr_wb, regwrite_dat_wb, mem_err);
    end
    reset     = 1'b1;
    err_model = 1'b0;
    exp_wb    = 1'b0;
    exp_adr   = 3'd0;
    exp_dat   = 16'h0000;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu();
    run_op(1'b0, 1'b0, 16'h1234, 16'h0000, 3'd3, 1'b1, 0, 16'h0000, 1'b0);
  endtask

  task automatic test_load();
    run_op(1'b0, 1'b1, 16'h0040, 16'h0000, 3'd5, 1'b1, 1, 16'hBEEF, 1'b0);
  endtask

  task automatic test_store();
    run_op(1'b1, 1'b0, 16'h0010, 16'h00AA, 3'd2, 1'b0, 3, 16'h0000, 1'b0);
  endtask

  task automatic test_ack_at_limit();
    run_op(1'b0, 1'b1, 16'h0044, 16'h0000, 3'd6, 1'b1, TIMEOUT_T, 16'hCAFE, 1'b1);
  endtask

  task automatic test_timeout();
    run_op(1'b0, 1'b1, 16'h0048, 16'h0000, 3'd7, 1'b1, 99, 16'hDEAD, 1'b0);
    run_op(1'b0, 1'b0, 16'h5678, 16'h0000, 3'd1, 1'b1, 0, 16'h0000, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    main_mem_write            = 1'b0;
    regwrite_dat_controll_mem = 1'b1;
    ALUres_mem                = 16'h0080;
    regwrite_adr_mem          = 3'd4;
    regwrite_mem              = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    n_checks++;
    if (dmem_bus.dmem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_req: got %b expected 1", dmem_bus.dmem_req);
    end
    reset = 1'b0;
    set_idle();
    #1;
    n_checks++;
    if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_wdata} !== 34'h0) begin
      n_fail++;
      $display("FAIL midwait_bus: got req=%b we=%b addr=%h wdata=%h expected all 0",
               dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_wdata);
    end
    n_checks++;
    if ({stall_mem, mem_err, regwrite_wb, regwrite_adr_wb, regwrite_dat_wb} !== 22'h0) begin
      n_fail++;
      $display("FAIL midwait_out: got stall=%b err=%b we=%b adr=%0d dat=%h expected all 0",
               stall_mem, mem_err, regwrite_wb, regwrite_adr_wb, regwrite_dat_wb);
    end
    err_model = 1'b0;
    exp_wb    = 1'b0;
    exp_adr   = 3'd0;
    exp_dat   = 16'h0000;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dmem_bus.dmem_ack   = 1'b1;
      dmem_bus.dmem_rdata = 16'h1357;
      @(posedge clk);
      #1;
      dmem_bus.dmem_ack = 1'b0;
      n_checks++;
      if ({dmem_bus.dmem_req, stall_mem, regwrite_wb, mem_err} !== 4'b0000) begin
        n_fail++;
        $display("FAIL spurious_ack i=%0d: got req=%b stall=%b we=%b err=%b expected all 0",
                 i, dmem_bus.dmem_req, stall_mem, regwrite_wb, mem_err);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int          kind;
      int          k;
      logic [15:0] a, w, r;
      logic [2:0]  ad;
      bit          rw, done_ack;
      kind     = int'($urandom_range(0, 3));
      k        = int'($urandom_range(1, TIMEOUT_T + 2));
      a        = 16'($urandom);
      w        = 16'($urandom);
      r        = 16'($urandom);
      ad       = 3'($urandom);
      rw       = 1'($urandom);
      done_ack = 1'($urandom);
      run_op(kind[1], kind[0], a, w, ad, rw, k, r, done_ack);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_ack_at_limit();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum WAIT cycles without dmem_ack before abort; legal range 1..255.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous active-low reset.
REQ-004 ALUres_mem  in  16  MEM-stage ALU result; load/store address; writeback data for non-load ops.
REQ-005 rd1_mem  in  16  store data.
REQ-006 regwrite_adr_mem  in  3  destination register.
REQ-007 main_mem_write  in  1  store request.
REQ-008 regwrite_dat_controll_mem  in  1  load request (writeback data comes from memory).
REQ-009 regwrite_mem  in  1  register write enable.
REQ-010 dmem_req  out  1  data-memory request, registered.
REQ-011 dmem_we  out  1  1 = write, 0 = read; registered.
REQ-012 dmem_addr, dmem_wdata  out  16 each  request address and write data; registered.
REQ-013 dmem_rdata  in  16  read data; valid in the dmem_ack cycle.
REQ-014 dmem_ack  in  1  one-cycle completion pulse.
REQ-015 stall_mem  out  1  combinational; 1 freezes IF..EX/MEM (upstream drives en_exmem = ~stall_mem).
REQ-016 regwrite_wb  out  1  MEM/WB write enable.
REQ-017 regwrite_adr_wb  out  3  MEM/WB destination register.
REQ-018 regwrite_dat_wb  out  16  MEM/WB write data.
REQ-019 mem_err  out  1  sticky timeout flag.

Function
REQ-020 mem_op = main_mem_write | regwrite_dat_controll_mem; if both are 1, the store takes priority and writeback data is ALUres_mem.
REQ-021 FSM states: IDLE, WAIT, DONE.
REQ-022 IDLE with mem_op=1: next state WAIT; register dmem_req=1, dmem_we=main_mem_write, dmem_addr=ALUres_mem, dmem_wdata=rd1_mem.
REQ-023 IDLE with mem_op=0: remain in IDLE.
REQ-024 WAIT: hold dmem_req and all dmem_* outputs stable until dmem_ack.
REQ-025 WAIT with dmem_ack=1: capture dmem_rdata into load_data; clear dmem_req next cycle; next state DONE.
REQ-026 dmem_ack in IDLE or DONE is ignored.
REQ-027 stall_mem = mem_op & (state != DONE).
REQ-028 Stall length: for ack in WAIT cycle k (k>=1), stall is k+1 cycles (minimum 2).
REQ-029 DONE always returns to IDLE in one cycle; the following EX/MEM contents are examined in IDLE.
REQ-030 MEM/WB update, stall_mem=0: regwrite_wb<=regwrite_mem; regwrite_adr_wb<=regwrite_adr_mem; regwrite_dat_wb<=load_data for a load, else ALUres_mem.
REQ-031 MEM/WB update, stall_mem=1: bubble, regwrite_wb<=0; adr/dat hold their values.
REQ-032 Non-memory op: latency 1 cycle, no stall.
REQ-033 Timeout: 8-bit counter cleared on entry to WAIT, incremented each WAIT cycle without ack.
REQ-034 When the count reaches TIMEOUT: drop dmem_req; set load_data=16'h0000; set mem_err=1; next state DONE.
REQ-035 Ack arriving in the same cycle as the count reaching TIMEOUT is a normal completion; mem_err is not set.
REQ-036 mem_err is cleared only by reset.

Reset
REQ-037 reset low, at any time including mid-WAIT: state=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0; counter=0; load_data=0; regwrite_wb=0, regwrite_adr_wb=0, regwrite_dat_wb=0; mem_err=0.
REQ-038 An abandoned memory request is not reissued after reset.

Structure
REQ-039 State enum and the TIMEOUT default value live in the shared cpu_pkg.
REQ-040 Timeout counter is one sub-module, mem_timer (clear, enable, terminal-count output); MEM/WB registers reuse flopr.

Verification
REQ-041 ALU op, ALUres_mem=16'h1234, regwrite_mem=1, regwrite_adr_mem=3 -> next cycle regwrite_wb=1, adr=3, dat=16'h1234; stall_mem never 1.
REQ-042 Load from 16'h0040, ack on first WAIT cycle with rdata=16'hBEEF -> stall_mem high exactly 2 cycles; then dat_wb=16'hBEEF, regwrite_wb=1.
REQ-043 Store 16'h00AA to 16'h0010, ack after 3 WAIT cycles -> dmem_we=1, addr/wdata stable through WAIT; stall_mem 4 cycles; regwrite_wb=0.
REQ-044 TIMEOUT=4, load, no ack -> req drops after 4 WAIT cycles; mem_err=1 stays set; dat_wb=16'h0000; next op proceeds.
REQ-045 reset low during WAIT -> dmem_req=0, stall_mem=0 next evaluation, mem_err=0; spurious ack after release is ignored.
